// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions: control-bundle layout and ALUOp encodings.
// Used by the ID/EX register and reusable by the EX/MEM and MEM/WB registers.
package pipe_pkg;

    localparam int CTRL_W = 9;

    // Bit positions inside the {ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Jump,ALUOp} bundle
    localparam int CB_ALUSRC   = 8;
    localparam int CB_MEMTOREG = 7;
    localparam int CB_REGWRITE = 6;
    localparam int CB_MEMREAD  = 5;
    localparam int CB_MEMWRITE = 4;
    localparam int CB_BRANCH   = 3;
    localparam int CB_JUMP     = 2;
    localparam int CB_ALUOP_HI = 1;
    localparam int CB_ALUOP_LO = 0;

    localparam logic [1:0] ALUOP_LDST = 2'b00;
    localparam logic [1:0] ALUOP_BR   = 2'b01;
    localparam logic [1:0] ALUOP_R    = 2'b10;
    localparam logic [1:0] ALUOP_I    = 2'b11;

endpackage

// File: rtl/pipe_field_reg.sv
// Field-group register: async clear, sync clear (bubble) with priority over enable.
// Latency 1 cycle; en=0 holds contents, clr=1 loads zero regardless of en.
module pipe_field_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_d;
    logic [W-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with control sanitising and a saturating bubble counter.
// Latency 1 cycle; Stall holds everything, Flush (or an invalid slot) loads a bubble.
module id_ex_pipe_reg
    import pipe_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int BCNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               Stall,
    input  logic               Flush,
    input  logic               ID_Valid,
    input  logic [CTRL_W-1:0]  ID_Ctrl,
    input  logic [XLEN-1:0]    ID_PC,
    input  logic [XLEN-1:0]    ID_RD1,
    input  logic [XLEN-1:0]    ID_RD2,
    input  logic [XLEN-1:0]    ID_Imm,
    input  logic [RADDR_W-1:0] ID_Rs1,
    input  logic [RADDR_W-1:0] ID_Rs2,
    input  logic [RADDR_W-1:0] ID_Rd,
    input  logic [3:0]         ID_Funct,
    output logic               EX_Valid,
    output logic               EX_ALUSrc,
    output logic               EX_MemtoReg,
    output logic               EX_RegWrite,
    output logic               EX_MemRead,
    output logic               EX_MemWrite,
    output logic               EX_Branch,
    output logic               EX_Jump,
    output logic [1:0]         EX_ALUOp,
    output logic [XLEN-1:0]    EX_PC,
    output logic [XLEN-1:0]    EX_RD1,
    output logic [XLEN-1:0]    EX_RD2,
    output logic [XLEN-1:0]    EX_Imm,
    output logic [RADDR_W-1:0] EX_Rs1,
    output logic [RADDR_W-1:0] EX_Rs2,
    output logic [RADDR_W-1:0] EX_Rd,
    output logic [3:0]         EX_Funct,
    output logic [BCNT_W-1:0]  BubbleCount
);

    localparam int DATA_W = 4 * XLEN + 4;
    localparam int IDX_W  = 3 * RADDR_W;

    logic               load_en;
    logic               bubble;
    logic [CTRL_W-1:0]  ctrl_clean;
    logic [CTRL_W:0]    ctrl_grp_q;
    logic [DATA_W-1:0]  data_grp_q;
    logic [IDX_W-1:0]   idx_grp_q;
    logic [BCNT_W-1:0]  bcnt_d;
    logic [BCNT_W-1:0]  bcnt_q;

    assign load_en = ~Stall;
    assign bubble  = Flush | (~Stall & ~ID_Valid);

    // Case-equality so x/z control bits from decode never reach EX as 1.
    always_comb begin
        ctrl_clean = '0;
        for (int i = 0; i < CTRL_W; i++) begin
            ctrl_clean[i] = (ID_Ctrl[i] === 1'b1);
        end
        if (ctrl_clean[CB_MEMREAD] && ctrl_clean[CB_MEMWRITE]) begin
            ctrl_clean[CB_MEMREAD]  = 1'b0;
            ctrl_clean[CB_MEMWRITE] = 1'b0;
            ctrl_clean[CB_REGWRITE] = 1'b0;
        end
        if (ID_Rd == '0) begin
            ctrl_clean[CB_REGWRITE] = 1'b0;
        end
    end

    pipe_field_reg #(.W(CTRL_W + 1)) u_ctrl_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (load_en),
        .clr   (bubble),
        .d     ({1'b1, ctrl_clean}),
        .q     (ctrl_grp_q)
    );

    pipe_field_reg #(.W(DATA_W)) u_data_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (load_en),
        .clr   (bubble),
        .d     ({ID_PC, ID_RD1, ID_RD2, ID_Imm, ID_Funct}),
        .q     (data_grp_q)
    );

    pipe_field_reg #(.W(IDX_W)) u_idx_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (load_en),
        .clr   (bubble),
        .d     ({ID_Rs1, ID_Rs2, ID_Rd}),
        .q     (idx_grp_q)
    );

    assign EX_Valid    = ctrl_grp_q[CTRL_W];
    assign EX_ALUSrc   = ctrl_grp_q[CB_ALUSRC];
    assign EX_MemtoReg = ctrl_grp_q[CB_MEMTOREG];
    assign EX_RegWrite = ctrl_grp_q[CB_REGWRITE];
    assign EX_MemRead  = ctrl_grp_q[CB_MEMREAD];
    assign EX_MemWrite = ctrl_grp_q[CB_MEMWRITE];
    assign EX_Branch   = ctrl_grp_q[CB_BRANCH];
    assign EX_Jump     = ctrl_grp_q[CB_JUMP];
    assign EX_ALUOp    = ctrl_grp_q[CB_ALUOP_HI:CB_ALUOP_LO];

    assign {EX_PC, EX_RD1, EX_RD2, EX_Imm, EX_Funct} = data_grp_q;
    assign {EX_Rs1, EX_Rs2, EX_Rd}                   = idx_grp_q;

    // Saturates at all-ones so long debug runs never wrap to a misleading small count.
    always_comb begin
        bcnt_d = bcnt_q;
        if (bubble && (bcnt_q != {BCNT_W{1'b1}})) begin
            bcnt_d = bcnt_q + {{(BCNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q <= '0;
        end else begin
            bcnt_q <= bcnt_d;
        end
    end

    assign BubbleCount = bcnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed scenarios plus random traffic against a reference model.
module tb_id_ex_pipe_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Stall, Flush, ID_Valid;
    logic [8:0]  ID_Ctrl;
    logic [31:0] ID_PC, ID_RD1, ID_RD2, ID_Imm;
    logic [4:0]  ID_Rs1, ID_Rs2, ID_Rd;
    logic [3:0]  ID_Funct;

    logic        EX_Valid, EX_ALUSrc, EX_MemtoReg, EX_RegWrite, EX_MemRead;
    logic        EX_MemWrite, EX_Branch, EX_Jump;
    logic [1:0]  EX_ALUOp;
    logic [31:0] EX_PC, EX_RD1, EX_RD2, EX_Imm;
    logic [4:0]  EX_Rs1, EX_Rs2, EX_Rd;
    logic [3:0]  EX_Funct;
    logic [15:0] BubbleCount;

    int total = 0;
    int bad   = 0;

    // Reference model: the instruction EX should hold, as plain fields.
    logic        m_valid;
    logic [8:0]  m_ctrl;
    logic [31:0] m_pc, m_rd1, m_rd2, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [3:0]  m_funct;
    int          m_bcnt;

    always #5 clk = ~clk;

    id_ex_pipe_reg dut (
        .clk(clk), .rst_n(rst_n), .Stall(Stall), .Flush(Flush), .ID_Valid(ID_Valid),
        .ID_Ctrl(ID_Ctrl), .ID_PC(ID_PC), .ID_RD1(ID_RD1), .ID_RD2(ID_RD2), .ID_Imm(ID_Imm),
        .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2), .ID_Rd(ID_Rd), .ID_Funct(ID_Funct),
        .EX_Valid(EX_Valid), .EX_ALUSrc(EX_ALUSrc), .EX_MemtoReg(EX_MemtoReg),
        .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
        .EX_Branch(EX_Branch), .EX_Jump(EX_Jump), .EX_ALUOp(EX_ALUOp),
        .EX_PC(EX_PC), .EX_RD1(EX_RD1), .EX_RD2(EX_RD2), .EX_Imm(EX_Imm),
        .EX_Rs1(EX_Rs1), .EX_Rs2(EX_Rs2), .EX_Rd(EX_Rd), .EX_Funct(EX_Funct),
        .BubbleCount(BubbleCount)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_valid = 0; m_ctrl = '0; m_pc = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;
        m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_funct = '0;
    endtask

    // One clock edge worth of behaviour, from the inputs currently applied.
    task automatic model_edge();
        bit alusrc, m2r, rw, mr, mw, br, jmp, both;
        if (Flush || (!Stall && !ID_Valid)) begin
            model_clear();
            m_bcnt = (m_bcnt < 65535) ? m_bcnt + 1 : 65535;
        end else if (!Stall) begin
            alusrc = (ID_Ctrl[8] === 1'b1);
            m2r    = (ID_Ctrl[7] === 1'b1);
            rw     = (ID_Ctrl[6] === 1'b1);
            mr     = (ID_Ctrl[5] === 1'b1);
            mw     = (ID_Ctrl[4] === 1'b1);
            br     = (ID_Ctrl[3] === 1'b1);
            jmp    = (ID_Ctrl[2] === 1'b1);
            both   = mr && mw;
            m_ctrl = {alusrc, m2r, rw && !both && (ID_Rd != 0), mr && !both, mw && !both,
                      br, jmp, ID_Ctrl[1] === 1'b1, ID_Ctrl[0] === 1'b1};
            m_valid = 1;
            m_pc = ID_PC; m_rd1 = ID_RD1; m_rd2 = ID_RD2; m_imm = ID_Imm;
            m_rs1 = ID_Rs1; m_rs2 = ID_Rs2; m_rd = ID_Rd; m_funct = ID_Funct;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, EX_Valid, m_valid);
        chk({tag, ".ctrl"}, {EX_ALUSrc, EX_MemtoReg, EX_RegWrite, EX_MemRead, EX_MemWrite,
                             EX_Branch, EX_Jump, EX_ALUOp}, m_ctrl);
        chk({tag, ".data"}, {EX_PC, EX_RD1}, {m_pc, m_rd1});
        chk({tag, ".data2"}, {EX_RD2, EX_Imm}, {m_rd2, m_imm});
        chk({tag, ".idx"}, {EX_Rs1, EX_Rs2, EX_Rd, EX_Funct}, {m_rs1, m_rs2, m_rd, m_funct});
        chk({tag, ".bcnt"}, BubbleCount, m_bcnt[15:0]);
    endtask

    // Apply inputs (called just after a negedge), clock once, check at the next negedge.
    task automatic step(input logic st, input logic fl, input logic vl, input logic [8:0] c,
                        input logic [4:0] rd, input bit do_chk, input string tag);
        Stall = st; Flush = fl; ID_Valid = vl; ID_Ctrl = c; ID_Rd = rd;
        ID_PC = $urandom; ID_RD1 = $urandom; ID_RD2 = $urandom; ID_Imm = $urandom;
        ID_Rs1 = 5'($urandom); ID_Rs2 = 5'($urandom); ID_Funct = 4'($urandom);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (do_chk) check_all(tag);
    endtask

    initial begin
        logic [8:0]  c;
        logic [31:0] pre_pc;
        logic [4:0]  rd;

        rst_n = 0; Stall = 0; Flush = 0; ID_Valid = 0; ID_Ctrl = '0; ID_Rd = '0;
        ID_PC = '0; ID_RD1 = '0; ID_RD2 = '0; ID_Imm = '0; ID_Rs1 = '0; ID_Rs2 = '0; ID_Funct = '0;
        model_clear();
        m_bcnt = 0;
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1;

        // R-type load
        step(0, 0, 1, 9'b001000010, 5'd5, 1, "rtype");
        chk("rtype.regwrite", EX_RegWrite, 1'b1);
        chk("rtype.aluop", EX_ALUOp, pipe_pkg::ALUOP_R);
        chk("rtype.valid", EX_Valid, 1'b1);

        // Stall holds while ID changes underneath
        pre_pc = m_pc;
        for (int i = 0; i < 3; i++) step(1, 0, 1, 9'($urandom), 5'($urandom), 1, "stall");
        chk("stall.pc_held", EX_PC, pre_pc);
        chk("stall.bcnt_held", BubbleCount, 16'd0);

        // Flush beats Stall
        step(1, 1, 1, 9'b111100000, 5'd7, 1, "flush_stall");
        chk("flush_stall.bcnt", BubbleCount, 16'd1);

        // Sanitising: x bit, and MemRead+MemWrite conflict
        step(0, 0, 1, 9'b1x0010000, 5'd0, 1, "stype");
        chk("stype.memtoreg", EX_MemtoReg, 1'b0);
        chk("stype.memwrite", EX_MemWrite, 1'b1);
        step(0, 0, 1, 9'h1FF, 5'd9, 1, "allones");
        chk("allones.rw_mr_mw", {EX_RegWrite, EX_MemRead, EX_MemWrite}, 3'b000);

        // Asynchronous reset mid-cycle while RegWrite is set
        step(0, 0, 1, 9'b001000010, 5'd3, 1, "pre_reset");
        #2 rst_n = 0;
        #1;
        model_clear();
        m_bcnt = 0;
        check_all("async_reset");
        chk("async_reset.regwrite", EX_RegWrite, 1'b0);
        @(negedge clk);
        rst_n = 1;
        step(0, 0, 1, 9'b011100000, 5'd4, 1, "post_reset");

        // Random traffic, with a stalled reset thrown in part way
        for (int i = 0; i < 400; i++) begin
            c = 9'($urandom);
            for (int b = 0; b < 9; b++) if ($urandom_range(0, 7) == 0) c[b] = 1'bx;
            rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            step($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0,
                 $urandom_range(0, 4) != 0, c, rd, 1, "rand");
            if (i == 200) begin
                Stall = 1;
                #2 rst_n = 0;
                #1;
                model_clear();
                m_bcnt = 0;
                check_all("rand_reset");
                @(negedge clk);
                rst_n = 1;
            end
        end

        // Drive the counter to saturation
        while (m_bcnt < 16'hFFFE) step(0, 1, 1, 9'h0, 5'd1, 0, "fill");
        chk("sat.fffe", BubbleCount, 16'hFFFE);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 9'h0, 5'd1, 1, "sat");
        chk("sat.ffff", BubbleCount, 16'hFFFF);
        step(0, 1, 1, 9'h0, 5'd1, 1, "sat_hold");
        chk("sat_hold.ffff", BubbleCount, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
